// File: rtl/pipe_memory_pkg.sv
// Shared y86 definitions: instruction codes, status codes, the register-none
// marker, and the writeback-stage register layout with its bubble value.
// Also used by the fetch, decode, execute and writeback stages.
package pipe_memory_pkg;

  // Instruction codes
  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] ICmovXX = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  // Status codes
  localparam logic [3:0] SAok = 4'h1;
  localparam logic [3:0] SHlt = 4'h2;
  localparam logic [3:0] SAdr = 4'h3;
  localparam logic [3:0] SIns = 4'h4;

  // Register identifier meaning "no register"
  localparam logic [3:0] RNone = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } w_reg_t;

  localparam w_reg_t WBubble = '{
    stat:  SAok,
    icode: INop,
    dst_e: RNone,
    dst_m: RNone,
    val_e: 64'd0,
    val_m: 64'd0
  };

  function automatic logic icode_reads(input logic [3:0] icode);
    return (icode == IMrmovq) || (icode == IRet) || (icode == IPopq);
  endfunction

  function automatic logic icode_writes(input logic [3:0] icode);
    return (icode == IRmmovq) || (icode == ICall) || (icode == IPushq);
  endfunction

  // ret/popq address the stack through valA; everything else uses valE
  function automatic logic addr_from_val_a(input logic [3:0] icode);
    return (icode == IRet) || (icode == IPopq);
  endfunction

endpackage

// File: rtl/pipe_memory_data_memory.sv
// Byte-addressed data memory holding 64-bit little-endian words.
// Ports:
//   clk_i    - write clock
//   addr_i   - byte address of the word (caller guarantees addr <= DMEM_BYTES-8
//              whenever the read data is used or we_i is high)
//   we_i     - write strobe, word committed on rising edge
//   wdata_i  - write data
//   rdata_o  - asynchronous read of the addressed word
module data_memory #(
  parameter int unsigned DMEM_BYTES = 1024,
  localparam int unsigned AW = $clog2(DMEM_BYTES)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [7:0] mem_q [DMEM_BYTES];

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 8; k++) begin
      rdata_o[8*k +: 8] = mem_q[addr_i + AW'(k)];
    end
  end

  // No reset: contents survive a pipeline reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[addr_i + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/pipe_memory.sv
// Memory stage of the y86 pipeline plus the writeback-stage input register.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   M_*                     - memory-stage inputs from the execute stage
//   W_stall, W_bubble       - pipeline control for the W register
//   m_stat, m_valM          - combinational stage results (forwarding/control)
//   W_*                     - registered writeback-stage inputs
module pipe_memory
  import pipe_memory_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM
);

  localparam int unsigned AW = $clog2(DMEM_BYTES);
  localparam logic [63:0] MaxAddr = 64'(DMEM_BYTES - 8);

  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        dmem_error;
  logic        mem_we;
  logic [63:0] mem_rdata;
  w_reg_t      w_d, w_q;

  // Condition code is already folded into M_dstE upstream
  logic unused_cnd;
  assign unused_cnd = M_Cnd;

  always_comb begin
    mem_read   = icode_reads(M_icode);
    mem_write  = icode_writes(M_icode);
    mem_addr   = addr_from_val_a(M_icode) ? M_valA : M_valE;
    // Unsigned compare also catches huge addresses that would wrap
    dmem_error = (mem_read || mem_write) && (mem_addr > MaxAddr);
    m_valM     = (mem_read && !dmem_error) ? mem_rdata : 64'd0;
    m_stat     = dmem_error ? SAdr : M_stat;
    // Older faulting instruction in W must not see younger stores land
    mem_we     = mem_write && !dmem_error && (M_stat == SAok) &&
                 (w_q.stat == SAok) && !reset;
  end

  data_memory #(
    .DMEM_BYTES (DMEM_BYTES)
  ) u_dmem (
    .clk_i   (clk),
    .addr_i  (mem_addr[AW-1:0]),
    .we_i    (mem_we),
    .wdata_i (M_valA),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    w_d = w_q;
    if (reset) begin
      w_d = WBubble;
    end else if (W_stall) begin
      w_d = w_q;
    end else if (W_bubble) begin
      w_d = WBubble;
    end else begin
      w_d.stat  = m_stat;
      w_d.icode = M_icode;
      w_d.dst_e = M_dstE;
      w_d.dst_m = M_dstM;
      w_d.val_e = M_valE;
      w_d.val_m = m_valM;
    end
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;

endmodule

// File: tb/tb_pipe_memory.sv
module tb_pipe_memory;

  localparam int unsigned N = 1024;

  logic        clk = 1'b0;
  logic        reset, W_stall, W_bubble, M_Cnd;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;
  logic [63:0] m_valM, W_valE, W_valM;

  pipe_memory #(.DMEM_BYTES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM),
    .W_stall  (W_stall),
    .W_bubble (W_bubble),
    .m_stat   (m_stat),
    .m_valM   (m_valM),
    .W_stat   (W_stat),
    .W_icode  (W_icode),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM),
    .W_valE   (W_valE),
    .W_valM   (W_valM)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [7:0]  mdl_mem [N];
  logic [3:0]  e_stat = 4'h1, e_icode = 4'h1, e_dste = 4'hF, e_dstm = 4'hF;
  logic [63:0] e_vale = 64'd0, e_valm = 64'd0;

  // Last sampled combinational outputs, for directed checks
  logic [3:0]  obs_mstat;
  logic [63:0] obs_mvalm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [63:0] a);
    logic [63:0] v = 64'd0;
    for (int k = 0; k < 8; k++) v = v | (64'(mdl_mem[int'(a) + k]) << (8 * k));
    return v;
  endfunction

  task automatic step(input logic rst, input logic stl, input logic bub,
                      input logic [3:0] st, input logic [3:0] ic,
                      input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] de, input logic [3:0] dm);
    logic        rd, wr, err;
    logic [63:0] addr, x_valm;
    logic [3:0]  x_stat;
    @(negedge clk);
    reset = rst; W_stall = stl; W_bubble = bub; M_stat = st; M_icode = ic;
    M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm; M_Cnd = 1'($urandom);
    #1;
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    addr = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    err  = (rd || wr) && (addr > 64'(N) - 64'd8);
    x_valm = (rd && !err) ? mdl_read(addr) : 64'd0;
    x_stat = err ? 4'h3 : st;
    obs_mstat = m_stat;
    obs_mvalm = m_valM;
    chk("m_stat", 64'(m_stat), 64'(x_stat));
    chk("m_valM", m_valM, x_valm);
    @(posedge clk);
    if (wr && !err && st == 4'h1 && e_stat == 4'h1 && !rst)
      for (int k = 0; k < 8; k++) mdl_mem[int'(addr) + k] = va[8*k +: 8];
    if (rst || (!stl && bub)) begin
      e_stat = 4'h1; e_icode = 4'h1; e_dste = 4'hF; e_dstm = 4'hF;
      e_vale = 64'd0; e_valm = 64'd0;
    end else if (!stl) begin
      e_stat = x_stat; e_icode = ic; e_dste = de; e_dstm = dm;
      e_vale = ve; e_valm = x_valm;
    end
    #1;
    chk("W_stat",  64'(W_stat),  64'(e_stat));
    chk("W_icode", 64'(W_icode), 64'(e_icode));
    chk("W_dstE",  64'(W_dstE),  64'(e_dste));
    chk("W_dstM",  64'(W_dstM),  64'(e_dstm));
    chk("W_valE",  W_valE, e_vale);
    chk("W_valM",  W_valM, e_valm);
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 64'($urandom_range(0, 248));
      3:       return 64'($urandom_range(N - 64, N - 8));
      4:       return 64'($urandom_range(N - 7, N + 8));
      default: return {$urandom, $urandom} | 64'h0000_1000_0000_0000;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N; i++) mdl_mem[i] = 8'h00;
    reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; M_Cnd = 1'b0;
    M_stat = 4'h1; M_icode = 4'h1; M_valE = '0; M_valA = '0; M_dstE = 4'hF; M_dstM = 4'hF;

    // Reset loads bubble values even with stall asserted
    step(1, 1, 0, 4'h1, 4'h1, 0, 0, 4'h3, 4'h4);
    step(1, 0, 0, 4'h1, 4'h1, 0, 0, 4'h3, 4'h4);
    chk("reset_W_icode", 64'(W_icode), 64'h1);
    chk("reset_W_dstE",  64'(W_dstE),  64'hF);

    // Known-zero regions for randomized reads
    for (int a = 0; a < 256; a += 8) step(0, 0, 0, 4'h1, 4'h4, 64'(a), 64'd0, 4'hF, 4'hF);
    for (int a = N - 64; a <= N - 8; a += 8)
      step(0, 0, 0, 4'h1, 4'h4, 64'(a), 64'd0, 4'hF, 4'hF);

    // Store then load at 0x10
    step(0, 0, 0, 4'h1, 4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
    chk("byte_0x10", 64'(dut.u_dmem.mem_q[16]), 64'h88);
    step(0, 0, 0, 4'h1, 4'h5, 64'h10, 64'd0, 4'hF, 4'h2);
    chk("mrmovq_valM", obs_mvalm, 64'h1122334455667788);
    chk("W_valM_0x10", W_valM, 64'h1122334455667788);

    // pushq just past the last legal word
    step(0, 0, 0, 4'h1, 4'hA, 64'(N - 7), 64'hDEAD_BEEF_0000_0001, 4'h4, 4'hF);
    chk("push_adr_mstat", 64'(obs_mstat), 64'h3);
    chk("push_adr_Wstat", 64'(W_stat), 64'h3);
    step(0, 0, 0, 4'h1, 4'h1, 0, 0, 4'hF, 4'hF);
    step(0, 0, 0, 4'h1, 4'h5, 64'(N - 8), 0, 4'hF, 4'h1);
    chk("top_word_kept", obs_mvalm, 64'd0);

    // popq reads via valA
    step(0, 0, 0, 4'h1, 4'h4, 64'h20, 64'hCAFE_F00D_1234_5678, 4'hF, 4'hF);
    step(0, 0, 0, 4'h1, 4'hB, 64'h28, 64'h20, 4'h4, 4'h5);
    chk("popq_valM", obs_mvalm, 64'hCAFE_F00D_1234_5678);
    chk("popq_W_valE", W_valE, 64'h28);
    step(0, 0, 0, 4'h1, 4'h9, 64'h28, 64'h20, 4'h4, 4'hF);
    chk("ret_valM", obs_mvalm, 64'hCAFE_F00D_1234_5678);

    // Stall wins over bubble, then bubble alone
    for (int i = 0; i < 3; i++) step(0, 1, 1, 4'h1, 4'h6, 64'h77, 64'h0, 4'h2, 4'h3);
    chk("stall_W_valE", W_valE, 64'h28);
    step(0, 0, 1, 4'h1, 4'h6, 64'h77, 64'h0, 4'h2, 4'h3);
    chk("bubble_W_icode", 64'(W_icode), 64'h1);
    chk("bubble_W_dstE",  64'(W_dstE),  64'hF);
    chk("bubble_W_dstM",  64'(W_dstM),  64'hF);

    // Non-AOK M_stat, then non-AOK W_stat, both block stores
    step(0, 0, 0, 4'h4, 4'h4, 64'h40, 64'h5555_5555_5555_5555, 4'hF, 4'hF);
    chk("ins_mstat_pass", 64'(obs_mstat), 64'h4);
    step(0, 0, 0, 4'h2, 4'h1, 0, 0, 4'hF, 4'hF);
    step(0, 0, 0, 4'h1, 4'h4, 64'h40, 64'h6666_6666_6666_6666, 4'hF, 4'hF);
    chk("hlt_mstat_pass", 64'(obs_mstat), 64'h1);
    step(0, 0, 0, 4'h1, 4'h5, 64'h40, 0, 4'hF, 4'h1);
    chk("blocked_store", obs_mvalm, 64'd0);

    // Reset suppresses a store; contents survive
    step(0, 0, 0, 4'h1, 4'h4, 64'h30, 64'h0102_0304_0506_0708, 4'hF, 4'hF);
    step(1, 0, 0, 4'h1, 4'h4, 64'h30, 64'hFFFF_0000_FFFF_0000, 4'hF, 4'hF);
    chk("rst_W_icode", 64'(W_icode), 64'h1);
    step(0, 0, 0, 4'h1, 4'h5, 64'h30, 0, 4'hF, 4'h1);
    chk("rst_no_write", obs_mvalm, 64'h0102_0304_0506_0708);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [3:0] st;
      st = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), st, 4'($urandom_range(0, 11)),
           pick_addr(), ($urandom_range(0, 1) == 1) ? pick_addr() : {$urandom, $urandom},
           4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
